// File: rtl/spi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// spi_mem_responder_if
// Groups the SPI pins and the write-observation strobe bus of the PSRAM
// stand-in into one bundle.
//   sclk, mosi, cs_n : driven by the SPI master (async to the target clock)
//   miso, miso_oe    : driven by the target during a READ data phase
//   wr_strobe        : 1-cycle pulse per completed write byte
//   wr_addr, wr_data : byte address and value that accompany wr_strobe
// Modports: master (SPI master / bench side), slave (memory target side).
// -----------------------------------------------------------------------------
interface spi_mem_responder_if #(
   parameter int ADDR_W = 8
);
   logic              sclk;
   logic              mosi;
   logic              cs_n;
   logic              miso;
   logic              miso_oe;
   logic              wr_strobe;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output sclk, mosi, cs_n,
      input  miso, miso_oe, wr_strobe, wr_addr, wr_data
   );

   modport slave (
      input  sclk, mosi, cs_n,
      output miso, miso_oe, wr_strobe, wr_addr, wr_data
   );
endinterface

// File: rtl/spi_mem_responder.sv
// -----------------------------------------------------------------------------
// spi_mem_responder
// SPI mode-0 memory target (PSRAM stand-in). Decodes READ / WRITE opcodes,
// each followed by a 24-bit byte address, over an internal 2**ADDR_W byte
// array. All SPI pins are oversampled in the clk domain; there is no second
// clock.
// Ports:
//   clk  : system clock, at least 4x the SPI clock
//   rst  : synchronous active-high reset (also clears the memory)
//   bus  : spi_mem_responder_if.slave -- sclk/mosi/cs_n in,
//          miso/miso_oe/wr_strobe/wr_addr/wr_data out (all registered)
// -----------------------------------------------------------------------------
module spi_mem_responder #(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] CMD_READ  = 8'h03,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_mem_responder_if.slave    bus
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_RDATA  = 3'd3;
   localparam logic [2:0] ST_WDATA  = 3'd4;
   localparam logic [2:0] ST_IGNORE = 3'd5;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   // synchronisers and previous-value flops for edge detection
   logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
   logic mosi_meta_r, mosi_sync_r;
   logic cs_meta_r, cs_sync_r, cs_prev_r;

   // protocol state
   logic [2:0]        state_r;
   logic [4:0]        bit_cnt_r;
   logic [7:0]        shreg_r;
   logic [ADDR_W-1:0] addr_r;
   logic              is_read_r;

   // registered outputs
   logic              miso_r;
   logic              miso_oe_r;
   logic              wr_strobe_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [7:0]        wr_data_r;

   logic [7:0]        mem_r [DEPTH];

   // decoded events
   logic              rise_s;
   logic              fall_s;
   logic              cs_fall_s;
   logic              byte_done_s;
   logic              wr_fire_s;
   logic [7:0]        shift_in_s;
   logic [ADDR_W-1:0] addr_shift_s;

   assign rise_s       = sclk_sync_r & ~sclk_prev_r;
   assign fall_s       = ~sclk_sync_r & sclk_prev_r;
   assign cs_fall_s    = cs_prev_r & ~cs_sync_r;
   assign byte_done_s  = (bit_cnt_r == 5'd7);
   assign shift_in_s   = {shreg_r[6:0], mosi_sync_r};
   // shifting all 24 address bits through an ADDR_W-wide register leaves
   // exactly the low ADDR_W bits once the address phase is complete
   assign addr_shift_s = {addr_r[ADDR_W-2:0], mosi_sync_r};
   // a deasserted chip select suppresses the byte, so a partial byte never commits
   assign wr_fire_s    = (state_r == ST_WDATA) && !cs_sync_r && rise_s && byte_done_s;

   assign bus.miso      = miso_r;
   assign bus.miso_oe   = miso_oe_r;
   assign bus.wr_strobe = wr_strobe_r;
   assign bus.wr_addr   = wr_addr_r;
   assign bus.wr_data   = wr_data_r;

   // two-flop synchronisers for the SPI pins plus one history flop for edges
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_meta_r <= 1'b0;
         sclk_sync_r <= 1'b0;
         sclk_prev_r <= 1'b0;
         mosi_meta_r <= 1'b0;
         mosi_sync_r <= 1'b0;
         cs_meta_r   <= 1'b1;
         cs_sync_r   <= 1'b1;
         cs_prev_r   <= 1'b1;
      end else begin
         sclk_meta_r <= bus.sclk;
         sclk_sync_r <= sclk_meta_r;
         sclk_prev_r <= sclk_sync_r;
         mosi_meta_r <= bus.mosi;
         mosi_sync_r <= mosi_meta_r;
         cs_meta_r   <= bus.cs_n;
         cs_sync_r   <= cs_meta_r;
         cs_prev_r   <= cs_sync_r;
      end
   end

   // byte array: cleared by reset, written once per completed WRITE byte
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (wr_fire_s) begin
         mem_r[addr_r] <= shift_in_s;
      end
   end

   // command / address / data sequencer and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 5'd0;
         shreg_r     <= 8'h00;
         addr_r      <= '0;
         is_read_r   <= 1'b0;
         miso_r      <= 1'b0;
         miso_oe_r   <= 1'b0;
         wr_strobe_r <= 1'b0;
         wr_addr_r   <= '0;
         wr_data_r   <= 8'h00;
      end else begin
         wr_strobe_r <= 1'b0;
         if (cs_sync_r) begin
            // deselect wins over any sclk edge seen in the same cycle
            state_r   <= ST_IDLE;
            bit_cnt_r <= 5'd0;
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (cs_fall_s) begin
                     state_r   <= ST_CMD;
                     bit_cnt_r <= 5'd0;
                     shreg_r   <= 8'h00;
                  end
               end
               ST_CMD: begin
                  if (rise_s) begin
                     shreg_r <= shift_in_s;
                     if (byte_done_s) begin
                        bit_cnt_r <= 5'd0;
                        if (shift_in_s == CMD_READ) begin
                           is_read_r <= 1'b1;
                           state_r   <= ST_ADDR;
                        end else if (shift_in_s == CMD_WRITE) begin
                           is_read_r <= 1'b0;
                           state_r   <= ST_ADDR;
                        end else begin
                           state_r <= ST_IGNORE;
                        end
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end
               ST_ADDR: begin
                  if (rise_s) begin
                     addr_r <= addr_shift_s;
                     if (bit_cnt_r == 5'd23) begin
                        bit_cnt_r <= 5'd0;
                        if (is_read_r) begin
                           // prefetch byte 0 so the very next fall can present its bit 7
                           shreg_r <= mem_r[addr_shift_s];
                           addr_r  <= addr_shift_s + ADDR_ONE;
                           state_r <= ST_RDATA;
                        end else begin
                           state_r <= ST_WDATA;
                        end
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end
               ST_RDATA: begin
                  if (fall_s) begin
                     miso_r    <= shreg_r[7];
                     miso_oe_r <= 1'b1;
                     if (byte_done_s) begin
                        shreg_r   <= mem_r[addr_r];
                        addr_r    <= addr_r + ADDR_ONE;
                        bit_cnt_r <= 5'd0;
                     end else begin
                        shreg_r   <= {shreg_r[6:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end
               ST_WDATA: begin
                  if (rise_s) begin
                     shreg_r <= shift_in_s;
                     if (byte_done_s) begin
                        wr_strobe_r <= 1'b1;
                        wr_addr_r   <= addr_r;
                        wr_data_r   <= shift_in_s;
                        addr_r      <= addr_r + ADDR_ONE;
                        bit_cnt_r   <= 5'd0;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end
               ST_IGNORE: begin
                  miso_r    <= 1'b0;
                  miso_oe_r <= 1'b0;
               end
               default: begin
                  state_r   <= ST_IDLE;
                  bit_cnt_r <= 5'd0;
                  miso_r    <= 1'b0;
                  miso_oe_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_responder
// Self-checking bench: a task-level SPI mode-0 master drives the target, a
// plain byte-array model tracks memory contents, a queue holds the write
// strobes the model predicts, and a per-cycle compare process matches the
// DUT's strobe bus and output-enable against it. Directed cases pin literal
// values; a randomized phase exercises arbitrary addresses and burst lengths.
// -----------------------------------------------------------------------------
module tb_spi_mem_responder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   spi_mem_responder_if #(.ADDR_W(8)) sif ();

   spi_mem_responder #(
      .ADDR_W    (8),
      .CMD_READ  (8'h03),
      .CMD_WRITE (8'h02)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] model_mem [256];
   wr_t        exp_q [$];
   logic [7:0] rd_buf [16];
   logic [7:0] wr_buf [16];
   int         half = 4;
   bit         oe_low_chk = 1'b0;
   logic       smp_miso;
   logic       smp_oe;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // one mode-0 bit: data set while sclk low, rise, hold, sample miso late in the high phase, fall
   task automatic bit_xfer(input logic b);
      sif.mosi = b;
      repeat (half) @(posedge clk);
      sif.sclk = 1'b1;
      repeat (half) @(posedge clk);
      @(negedge clk);
      smp_miso = sif.miso;
      smp_oe   = sif.miso_oe;
      sif.sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) bit_xfer(v[i]);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) bit_xfer(a[i]);
   endtask

   task automatic begin_xfer();
      sif.cs_n = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic end_xfer();
      repeat (half) @(posedge clk);
      sif.cs_n = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("strobes_outstanding", exp_q.size(), 0);
   endtask

   task automatic spi_write(input logic [23:0] addr, input int n, input int extra_bits);
      logic [7:0] a;
      oe_low_chk = 1'b1;
      begin_xfer();
      send_byte(8'h02);
      send_addr(addr);
      for (int k = 0; k < n; k++) begin
         a = 8'(addr[7:0] + k[7:0]);
         for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
               exp_q.push_back('{a: a, d: wr_buf[k]});
               model_mem[a] = wr_buf[k];
            end
            bit_xfer(wr_buf[k][i]);
         end
      end
      for (int i = 0; i < extra_bits; i++) bit_xfer(1'($urandom_range(0, 1)));
      end_xfer();
      oe_low_chk = 1'b0;
   endtask

   task automatic spi_read(input logic [23:0] addr, input int n);
      logic [7:0] v;
      begin_xfer();
      send_byte(8'h03);
      send_addr(addr);
      for (int k = 0; k < n; k++) begin
         for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'($urandom_range(0, 1)));
            v[i] = smp_miso;
         end
         chk("rd_miso_oe", {31'd0, smp_oe}, 32'd1);
         rd_buf[k] = v;
      end
      end_xfer();
   endtask

   task automatic spi_ignore(input logic [7:0] op, input int nbits);
      oe_low_chk = 1'b1;
      begin_xfer();
      send_byte(op);
      for (int i = 0; i < nbits; i++) bit_xfer(1'($urandom_range(0, 1)));
      end_xfer();
      oe_low_chk = 1'b0;
   endtask

   task automatic read_vs_model(input logic [23:0] addr, input int n);
      spi_read(addr, n);
      for (int k = 0; k < n; k++)
         chk("rd_model", {24'd0, rd_buf[k]}, {24'd0, model_mem[8'(addr[7:0] + k[7:0])]});
   endtask

   // per-cycle comparison of the strobe bus and output enable against the model
   always @(negedge clk) begin : compare_proc
      wr_t e;
      if (rst !== 1'b1) begin
         if (sif.wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", {24'd0, sif.wr_addr}, {24'd0, e.a});
               chk("wr_data", {24'd0, sif.wr_data}, {24'd0, e.d});
            end
         end
         if (oe_low_chk) chk("miso_oe_low", {31'd0, sif.miso_oe}, 32'd0);
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [23:0] ra;
      int          rn;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      sif.sclk = 1'b0;
      sif.mosi = 1'b0;
      sif.cs_n = 1'b1;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_miso",      {31'd0, sif.miso},      32'd0);
      chk("rst_miso_oe",   {31'd0, sif.miso_oe},   32'd0);
      chk("rst_wr_strobe", {31'd0, sif.wr_strobe}, 32'd0);
      chk("rst_wr_addr",   {24'd0, sif.wr_addr},   32'd0);
      chk("rst_wr_data",   {24'd0, sif.wr_data},   32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // 1) fresh memory reads zero
      spi_read(24'h000010, 1);
      chk("t1_rd10", {24'd0, rd_buf[0]}, 32'h00);

      // 2) two-byte write then read back
      wr_buf[0] = 8'hA5; wr_buf[1] = 8'h3C;
      spi_write(24'h000020, 2, 0);
      spi_read(24'h000020, 2);
      chk("t2_rd20", {24'd0, rd_buf[0]}, 32'hA5);
      chk("t2_rd21", {24'd0, rd_buf[1]}, 32'h3C);

      // 3) address wrap on write and read
      wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
      spi_write(24'h0000FF, 2, 0);
      spi_read(24'h0000FF, 2);
      chk("t3_rdFF", {24'd0, rd_buf[0]}, 32'h11);
      chk("t3_rd00", {24'd0, rd_buf[1]}, 32'h22);

      // 4) partial trailing byte is discarded
      wr_buf[0] = 8'h77;
      spi_write(24'h000040, 1, 4);
      spi_read(24'h000040, 1);
      chk("t4_rd40", {24'd0, rd_buf[0]}, 32'h77);
      spi_read(24'h000041, 1);
      chk("t4_rd41", {24'd0, rd_buf[0]}, 32'h00);

      // 5) unknown opcode is ignored, memory unchanged
      spi_ignore(8'h0B, 32);
      spi_read(24'h000020, 2);
      chk("t5_rd20", {24'd0, rd_buf[0]}, 32'hA5);
      chk("t5_rd21", {24'd0, rd_buf[1]}, 32'h3C);

      // randomized traffic against the byte-array model
      for (int t = 0; t < 30; t++) begin
         half = int'($urandom_range(3, 5));
         ra   = 24'($urandom());
         if (t % 3 == 0) ra[7:0] = 8'hFE;
         rn   = int'($urandom_range(1, 4));
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k < rn; k++) wr_buf[k] = 8'($urandom());
            spi_write(ra, rn, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
         end else begin
            read_vs_model(ra, rn);
         end
      end
      half = 4;
      read_vs_model(24'hABCD20, 2);

      // 6) reset in the middle of a read burst
      begin_xfer();
      send_byte(8'h03);
      send_addr(24'h000020);
      for (int i = 0; i < 12; i++) bit_xfer(1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_miso",      {31'd0, sif.miso},      32'd0);
      chk("t6_miso_oe",   {31'd0, sif.miso_oe},   32'd0);
      chk("t6_wr_strobe", {31'd0, sif.wr_strobe}, 32'd0);
      chk("t6_wr_addr",   {24'd0, sif.wr_addr},   32'd0);
      chk("t6_wr_data",   {24'd0, sif.wr_data},   32'd0);
      @(negedge clk);
      sif.cs_n = 1'b1;
      rst      = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      repeat (8) @(posedge clk);
      spi_read(24'h000020, 2);
      chk("t6_rd20", {24'd0, rd_buf[0]}, 32'h00);
      chk("t6_rd21", {24'd0, rd_buf[1]}, 32'h00);
      read_vs_model(24'h0000FF, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
